// File: rtl/bin_bcd_pkg.sv
// Shared types and constants for the binary <-> packed BCD converter.
package bin_bcd_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    localparam logic MODE_B2D = 1'b0;
    localparam logic MODE_D2B = 1'b1;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    function automatic int unsigned nd_for_width(input int unsigned w);
        return (w + 2) / 3;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit correction step: +3 when >= 5 going to BCD, -3 when >= 8 coming from BCD.
module bcd_digit_adj
    import bin_bcd_pkg::*;
(
    input  logic       dir_i,
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (dir_i == MODE_B2D) begin
            if (digit_i >= 4'd5) digit_o = digit_i + 4'd3;
        end else begin
            if (digit_i >= 4'd8) digit_o = digit_i - 4'd3;
        end
    end

endmodule

// File: rtl/bin_bcd_conv.sv
// Sequential binary <-> packed BCD converter, one shift per cycle, start/done handshake.
// Define BIN_BCD_LZ_BLANK_EN to blank leading zero digits (above digit 0) of mode 0 results.
module bin_bcd_conv
    import bin_bcd_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned ND     = nd_for_width(W),
    parameter bit          SIGNED = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    input  logic [W-1:0]    binary_in,
    input  logic [4*ND-1:0] bcd_in,
    input  logic            sign_in,
    output logic [W-1:0]    binary_out,
    output logic [4*ND-1:0] bcd_out,
    output logic            sign_out,
    output logic            busy,
    output logic            done,
    output logic            error
);

    localparam int unsigned BW   = 4 * ND;
    localparam int unsigned CntW = $clog2(W);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic            sign_q, sign_d;
    logic            bad_q, bad_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [W-1:0]    bin_q, bin_d;
    logic [W-1:0]    binary_out_q, binary_out_d;
    logic [BW-1:0]   bcd_out_q, bcd_out_d;
    logic            sign_out_q, sign_out_d;
    logic            error_q, error_d;

    logic            last_iter;
    logic [BW+W-1:0] shr;
    logic [BW-1:0]   adj_in, adj_out;
    logic [BW-1:0]   bcd_nxt, bcd_res;
    logic [W-1:0]    bin_nxt, mag_in;
    logic            neg_in, rng_err;

    assign last_iter = (cnt_q == CntW'(W - 1));
    assign shr       = {1'b0, bcd_q, bin_q[W-1:1]};
    // Mode 0 corrects before the left shift, mode 1 after the right shift.
    assign adj_in    = (mode_q == MODE_B2D) ? bcd_q : shr[BW+W-1:W];

    for (genvar i = 0; i < int'(ND); i++) begin : g_adj
        bcd_digit_adj u_adj (
            .dir_i   (mode_q),
            .digit_i (adj_in[4*i +: 4]),
            .digit_o (adj_out[4*i +: 4])
        );
    end

    always_comb begin
        if (mode_q == MODE_B2D) begin
            {bcd_nxt, bin_nxt} = {adj_out[BW-2:0], bin_q, 1'b0};
        end else begin
            bcd_nxt = adj_out;
            bin_nxt = shr[W-1:0];
        end
    end

`ifdef BIN_BCD_LZ_BLANK_EN
    logic lz_lead;
    always_comb begin
        bcd_res = bcd_nxt;
        lz_lead = 1'b1;
        for (int i = int'(ND) - 1; i >= 1; i--) begin
            if (lz_lead && bcd_nxt[4*i +: 4] == 4'h0) begin
                bcd_res[4*i +: 4] = BCD_BLANK;
            end else begin
                lz_lead = 1'b0;
            end
        end
    end
`else
    assign bcd_res = bcd_nxt;
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StLoad;
            StLoad:  state_d = StShift;
            StShift: if (last_iter) state_d = StDone;
            StDone:  if (!start) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            StLoad, StShift: busy = 1'b1;
            StDone:          done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        sign_d       = sign_q;
        bad_d        = bad_q;
        bcd_d        = bcd_q;
        bin_d        = bin_q;
        binary_out_d = binary_out_q;
        bcd_out_d    = bcd_out_q;
        sign_out_d   = sign_out_q;
        error_d      = error_q;
        neg_in       = SIGNED && binary_in[W-1];
        mag_in       = neg_in ? (~binary_in + W'(1)) : binary_in;
        // Signed range: only -2^(W-1) may use the top magnitude bit.
        rng_err      = 1'b0;
        if (SIGNED && bin_nxt[W-1]) rng_err = !(sign_q && bin_nxt[W-2:0] == '0);

        case (state_q)
            StLoad: begin
                mode_d = mode;
                cnt_d  = '0;
                bad_d  = 1'b0;
                if (mode == MODE_B2D) begin
                    bcd_d  = '0;
                    bin_d  = mag_in;
                    sign_d = neg_in;
                end else begin
                    bcd_d  = bcd_in;
                    bin_d  = '0;
                    sign_d = SIGNED && sign_in;
                    for (int i = 0; i < int'(ND); i++) begin
                        if (bcd_in[4*i +: 4] > 4'd9) bad_d = 1'b1;
                    end
                end
            end
            StShift: begin
                cnt_d = cnt_q + CntW'(1);
                bcd_d = bcd_nxt;
                bin_d = bin_nxt;
                if (last_iter) begin
                    if (mode_q == MODE_B2D) begin
                        bcd_out_d  = bcd_res;
                        sign_out_d = sign_q;
                        error_d    = 1'b0;
                    end else if (bad_q || (bcd_nxt != '0) || rng_err) begin
                        binary_out_d = '0;
                        error_d      = 1'b1;
                    end else begin
                        binary_out_d = sign_q ? (~bin_nxt + W'(1)) : bin_nxt;
                        error_d      = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            mode_q       <= MODE_B2D;
            sign_q       <= 1'b0;
            bad_q        <= 1'b0;
            bcd_q        <= '0;
            bin_q        <= '0;
            binary_out_q <= '0;
            bcd_out_q    <= '0;
            sign_out_q   <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            sign_q       <= sign_d;
            bad_q        <= bad_d;
            bcd_q        <= bcd_d;
            bin_q        <= bin_d;
            binary_out_q <= binary_out_d;
            bcd_out_q    <= bcd_out_d;
            sign_out_q   <= sign_out_d;
            error_q      <= error_d;
        end
    end

    assign binary_out = binary_out_q;
    assign bcd_out    = bcd_out_q;
    assign sign_out   = sign_out_q;
    assign error      = error_q;

endmodule

// File: tb/tb_bin_bcd_conv.sv
// Directed bench for bin_bcd_conv: unsigned and signed W=8 instances driven in parallel.
module tb_bin_bcd_conv;

    logic        clk, rst, start, mode, sign_in;
    logic [7:0]  binary_in;
    logic [11:0] bcd_in;

    logic [7:0]  u_bin, s_bin;
    logic [11:0] u_bcd, s_bcd;
    logic        u_sign, s_sign, u_busy, s_busy, u_done, s_done, u_err, s_err;

    int checks = 0;
    int errors = 0;

    bin_bcd_conv #(.W(8), .ND(3), .SIGNED(1'b0)) u_uns (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .binary_in(binary_in),
        .bcd_in(bcd_in), .sign_in(sign_in), .binary_out(u_bin), .bcd_out(u_bcd),
        .sign_out(u_sign), .busy(u_busy), .done(u_done), .error(u_err)
    );

    bin_bcd_conv #(.W(8), .ND(3), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .binary_in(binary_in),
        .bcd_in(bcd_in), .sign_in(sign_in), .binary_out(s_bin), .bcd_out(s_bcd),
        .sign_out(s_sign), .busy(s_busy), .done(s_done), .error(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [7:0]  bin;
        logic [11:0] bcd;
        logic        sgn;
        logic [11:0] u_bcd;
        logic        u_sign;
        logic [7:0]  u_bin;
        logic        u_err;
        logic [11:0] s_bcd;
        logic        s_sign;
        logic [7:0]  s_bin;
        logic        s_err;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected display form of a mode 0 result.
    function automatic logic [11:0] bl(input logic [11:0] v);
        logic [11:0] r;
        r = v;
`ifdef BIN_BCD_LZ_BLANK_EN
        if (r[11:8] == 4'h0) begin
            r[11:8] = 4'hF;
            if (r[7:4] == 4'h0) r[7:4] = 4'hF;
        end
`endif
        return r;
    endfunction

    task automatic wait_done(input string name, input int n0);
        int n;
        n = n0;
        while (!u_done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, " latency"}, n, 10);
        chk({name, " s_done"}, s_done, 1);
    endtask

    task automatic begin_conv(input string name, input logic m, input logic [7:0] b,
                              input logic [11:0] d, input logic s);
        mode      = m;
        binary_in = b;
        bcd_in    = d;
        sign_in   = s;
        start     = 1'b1;
        wait_done(name, 0);
    endtask

    task automatic end_conv(input string name);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({name, " done_drop"}, u_done, 0);
    endtask

    logic [11:0] eu_bcd, es_bcd;
    logic [7:0]  eu_bin, es_bin;
    logic        eu_sign, es_sign, eu_err, es_err;

    initial begin
        //           mode bin    bcd      sg  u_bcd   us u_bin  ue  s_bcd   ss s_bin  se
        vecs[0]  = '{1'b0, 8'd42, 12'h000, 1'b0, 12'h042, 1'b0, 8'h00, 1'b0, 12'h042, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 8'd0,  12'h000, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 8'hFF, 12'h000, 1'b0, 12'h255, 1'b0, 8'h00, 1'b0, 12'h001, 1'b1, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 8'h80, 12'h000, 1'b0, 12'h128, 1'b0, 8'h00, 1'b0, 12'h128, 1'b1, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 8'hD6, 12'h000, 1'b0, 12'h214, 1'b0, 8'h00, 1'b0, 12'h042, 1'b1, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 8'd7,  12'h000, 1'b0, 12'h007, 1'b0, 8'h00, 1'b0, 12'h007, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 8'd100, 12'h000, 1'b0, 12'h100, 1'b0, 8'h00, 1'b0, 12'h100, 1'b0, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 8'h7F, 12'h000, 1'b0, 12'h127, 1'b0, 8'h00, 1'b0, 12'h127, 1'b0, 8'h00, 1'b0};
        vecs[8]  = '{1'b1, 8'h00, 12'h255, 1'b0, 12'h000, 1'b0, 8'hFF, 1'b0, 12'h000, 1'b0, 8'h00, 1'b1};
        vecs[9]  = '{1'b1, 8'h00, 12'h256, 1'b0, 12'h000, 1'b0, 8'h00, 1'b1, 12'h000, 1'b0, 8'h00, 1'b1};
        vecs[10] = '{1'b1, 8'h00, 12'h1A3, 1'b0, 12'h000, 1'b0, 8'h00, 1'b1, 12'h000, 1'b0, 8'h00, 1'b1};
        vecs[11] = '{1'b1, 8'h00, 12'h128, 1'b1, 12'h000, 1'b0, 8'h80, 1'b0, 12'h000, 1'b0, 8'h80, 1'b0};
        vecs[12] = '{1'b1, 8'h00, 12'h128, 1'b0, 12'h000, 1'b0, 8'h80, 1'b0, 12'h000, 1'b0, 8'h00, 1'b1};
        vecs[13] = '{1'b1, 8'h00, 12'h127, 1'b0, 12'h000, 1'b0, 8'h7F, 1'b0, 12'h000, 1'b0, 8'h7F, 1'b0};
        vecs[14] = '{1'b1, 8'h00, 12'h000, 1'b1, 12'h000, 1'b0, 8'h00, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0};
        vecs[15] = '{1'b1, 8'h00, 12'h129, 1'b1, 12'h000, 1'b0, 8'h81, 1'b0, 12'h000, 1'b0, 8'h00, 1'b1};
        vecs[16] = '{1'b1, 8'h00, 12'h999, 1'b0, 12'h000, 1'b0, 8'h00, 1'b1, 12'h000, 1'b0, 8'h00, 1'b1};
        vecs[17] = '{1'b1, 8'h00, 12'h042, 1'b1, 12'h000, 1'b0, 8'h2A, 1'b0, 12'h000, 1'b0, 8'hD6, 1'b0};

        rst = 1'b1; start = 1'b0; mode = 1'b0; binary_in = '0; bcd_in = '0; sign_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst u_bcd", u_bcd, 0);
        chk("rst u_bin", u_bin, 0);
        chk("rst u_sign", u_sign, 0);
        chk("rst u_busy", u_busy, 0);
        chk("rst u_done", u_done, 0);
        chk("rst u_err", u_err, 0);
        chk("rst s_bcd", s_bcd, 0);
        chk("rst s_bin", s_bin, 0);

        eu_bcd = '0; es_bcd = '0; eu_bin = '0; es_bin = '0;
        eu_sign = 1'b0; es_sign = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (!vecs[i].mode) begin
                eu_bcd = bl(vecs[i].u_bcd); eu_sign = vecs[i].u_sign;
                es_bcd = bl(vecs[i].s_bcd); es_sign = vecs[i].s_sign;
            end else begin
                eu_bin = vecs[i].u_bin; es_bin = vecs[i].s_bin;
            end
            eu_err = vecs[i].u_err;
            es_err = vecs[i].s_err;
            begin_conv($sformatf("v%0d", i), vecs[i].mode, vecs[i].bin, vecs[i].bcd, vecs[i].sgn);
            chk($sformatf("v%0d u_bcd", i), u_bcd, eu_bcd);
            chk($sformatf("v%0d u_sign", i), u_sign, eu_sign);
            chk($sformatf("v%0d u_bin", i), u_bin, eu_bin);
            chk($sformatf("v%0d u_err", i), u_err, eu_err);
            chk($sformatf("v%0d s_bcd", i), s_bcd, es_bcd);
            chk($sformatf("v%0d s_sign", i), s_sign, es_sign);
            chk($sformatf("v%0d s_bin", i), s_bin, es_bin);
            chk($sformatf("v%0d s_err", i), s_err, es_err);
            end_conv($sformatf("v%0d", i));
        end

        // start dropped mid-SHIFT, operands scrambled while busy
        mode = 1'b0; binary_in = 8'd77; start = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("drop busy", u_busy, 1);
        start = 1'b0; binary_in = 8'hFF; mode = 1'b1; bcd_in = 12'h999;
        wait_done("drop", 4);
        chk("drop u_bcd", u_bcd, bl(12'h077));
        chk("drop s_bcd", s_bcd, bl(12'h077));
        chk("drop s_sign", s_sign, 0);
        chk("drop u_bin held", u_bin, 8'h2A);
        chk("drop s_bin held", s_bin, 8'hD6);
        @(posedge clk);
        #1;
        chk("drop done one cycle", u_done, 0);
        chk("drop idle busy", u_busy, 0);

        // reset on the 4th SHIFT cycle, then rst and start together
        mode = 1'b0; binary_in = 8'd200; start = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("rst4 busy", u_busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst4 u_bcd", u_bcd, 0);
        chk("rst4 u_bin", u_bin, 0);
        chk("rst4 u_busy", u_busy, 0);
        chk("rst4 u_done", u_done, 0);
        chk("rst4 s_bin", s_bin, 0);
        chk("rst4 s_sign", s_sign, 0);
        binary_in = 8'd49;
        @(posedge clk);
        #1;
        chk("rst+start busy", u_busy, 0);
        rst = 1'b0;
        begin_conv("after_rst", 1'b0, 8'd49, 12'h000, 1'b0);
        chk("after_rst u_bcd", u_bcd, bl(12'h049));
        chk("after_rst s_bcd", s_bcd, bl(12'h049));
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d done", k), u_done, 1);
            chk($sformatf("hold%0d busy", k), u_busy, 0);
            chk($sformatf("hold%0d u_bcd", k), u_bcd, bl(12'h049));
        end
        end_conv("hold");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end

endmodule
